// File: rtl/ped_xing_pkg.sv
// Shared types and constants for the pedestrian-crossing controller.
// Lamp vectors are ordered {red, yellow, green, walk, halt}.
package ped_xing_pkg;

  typedef enum logic [2:0] {
    ST_GREEN  = 3'd0,
    ST_YELLOW = 3'd1,
    ST_WALK   = 3'd2,
    ST_CLEAR  = 3'd3,
    ST_ALLRED = 3'd4,
    ST_NIGHT  = 3'd5
  } state_t;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
    logic walk;
    logic halt;
  } lamps_t;

  localparam lamps_t LAMPS_OFF    = 5'b00000;
  localparam lamps_t LAMPS_GREEN  = 5'b00101;
  localparam lamps_t LAMPS_YELLOW = 5'b01001;
  localparam lamps_t LAMPS_WALK   = 5'b10010;
  localparam lamps_t LAMPS_RED    = 5'b10000;  // halt supplied separately
  localparam lamps_t LAMPS_ALLRED = 5'b10001;

  // A duration d is loaded as d-1, so it must fit a CNT_W-bit timer.
  function automatic bit dur_ok(input longint d, input int w);
    return (d >= 1) && (d <= (longint'(1) << w));
  endfunction

endpackage

// File: rtl/ped_xing_ctrl_param_timer.sv
// Down-counter used for phase durations and the flash divider.
// Loads a value, decrements on request, flags zero.
module ped_phase_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             count <= RST_VAL;
    else if (load)          count <= load_val;
    else if (dec && !done)  count <= count - 1'b1;
  end

  assign done = (count == '0);

endmodule

// File: rtl/ped_xing_ctrl_param.sv
// Pedestrian-crossing light controller: vehicle head plus pedestrian head,
// latched requests, programmable phases, flashing clearance and night mode.
module ped_xing_ctrl_param
  import ped_xing_pkg::*;
#(
  parameter int N_BTN      = 2,
  parameter int CNT_W      = 8,
  parameter int GREEN_MIN  = 8,
  parameter int YELLOW_T   = 2,
  parameter int WALK_T     = 4,
  parameter int CLEAR_T    = 4,
  parameter int ALLRED_T   = 1,
  parameter int FLASH_HALF = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] x,
  input  logic             night,
  output logic             red,
  output logic             yellow,
  output logic             green,
  output logic             walk,
  output logic             halt,
  output logic             req_pending
);

  if (!dur_ok(GREEN_MIN, CNT_W) || !dur_ok(YELLOW_T, CNT_W) || !dur_ok(WALK_T, CNT_W) ||
      !dur_ok(CLEAR_T, CNT_W)   || !dur_ok(ALLRED_T, CNT_W) || !dur_ok(FLASH_HALF, CNT_W))
  begin : g_bad_duration
    $error("ped_xing_ctrl_param: every duration must be in 1..2**CNT_W");
  end

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_T - 1);
  localparam logic [CNT_W-1:0] CLEAR_LD  = CNT_W'(CLEAR_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_HALF - 1);

  state_t           state, state_next;
  logic             latch, latch_next;
  logic             flash, flash_next;
  logic             ph_load, ph_dec, ph_done;
  logic [CNT_W-1:0] ph_val, ph_count;
  logic             fl_load, fl_dec, fl_done;
  logic [CNT_W-1:0] fl_count;
  logic             pressed, flashing;
  lamps_t           lamps;

  ped_phase_timer #(.CNT_W(CNT_W), .RST_VAL(GREEN_LD)) u_phase (
    .clk      (clk),
    .reset    (reset),
    .load     (ph_load),
    .load_val (ph_val),
    .dec      (ph_dec),
    .count    (ph_count),
    .done     (ph_done)
  );

  ped_phase_timer #(.CNT_W(CNT_W), .RST_VAL(FLASH_LD)) u_flash (
    .clk      (clk),
    .reset    (reset),
    .load     (fl_load),
    .load_val (FLASH_LD),
    .dec      (fl_dec),
    .count    (fl_count),
    .done     (fl_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_GREEN;
      latch <= 1'b0;
      flash <= 1'b1;
    end else begin
      state <= state_next;
      latch <= latch_next;
      flash <= flash_next;
    end
  end

  assign pressed  = |x;
  assign flashing = (state == ST_CLEAR) || (state == ST_NIGHT);

  always_comb begin
    state_next = state;
    case (state)
      ST_GREEN:  if (night)             state_next = ST_NIGHT;
                 else if (ph_done && latch) state_next = ST_YELLOW;
      ST_YELLOW: if (ph_done)           state_next = ST_WALK;
      ST_WALK:   if (ph_done)           state_next = ST_CLEAR;
      ST_CLEAR:  if (ph_done)           state_next = ST_ALLRED;
      ST_ALLRED: if (ph_done)           state_next = ST_GREEN;
      ST_NIGHT:  if (!night)            state_next = ST_ALLRED;
      default:                          state_next = ST_GREEN;
    endcase
  end

  // Phase timer reloads on every state change; it idles at zero once done.
  always_comb begin
    ph_load = (state_next != state);
    ph_val  = '0;
    case (state_next)
      ST_GREEN:  ph_val = GREEN_LD;
      ST_YELLOW: ph_val = YELLOW_LD;
      ST_WALK:   ph_val = WALK_LD;
      ST_CLEAR:  ph_val = CLEAR_LD;
      ST_ALLRED: ph_val = ALLRED_LD;
      default:   ph_val = '0;
    endcase
    ph_dec = !ph_load && (ph_count != '0);
  end

  always_comb begin
    flash_next = flash;
    fl_load    = 1'b0;
    fl_dec     = 1'b0;
    if ((state_next != state) &&
        (state_next == ST_CLEAR || state_next == ST_NIGHT)) begin
      flash_next = 1'b1;
      fl_load    = 1'b1;
    end else if (flashing && state_next == state) begin
      if (fl_done) begin
        flash_next = ~flash;
        fl_load    = 1'b1;
      end else begin
        fl_dec = (fl_count != '0);
      end
    end
  end

  // Clearing on YELLOW->WALK takes priority over a press in the same cycle.
  always_comb begin
    latch_next = latch;
    if (state == ST_NIGHT || state_next == ST_NIGHT)
      latch_next = 1'b0;
    else if (state == ST_YELLOW && state_next == ST_WALK)
      latch_next = 1'b0;
    else if (pressed && state != ST_WALK)
      latch_next = 1'b1;
  end

  always_comb begin
    lamps = LAMPS_OFF;
    case (state)
      ST_GREEN:  lamps = LAMPS_GREEN;
      ST_YELLOW: lamps = LAMPS_YELLOW;
      ST_WALK:   lamps = LAMPS_WALK;
      ST_CLEAR:  begin lamps = LAMPS_RED; lamps.halt = flash; end
      ST_ALLRED: lamps = LAMPS_ALLRED;
      ST_NIGHT:  begin lamps = LAMPS_OFF; lamps.yellow = flash; lamps.halt = 1'b1; end
      default:   lamps = LAMPS_ALLRED;
    endcase
  end

  assign red         = lamps.red;
  assign yellow      = lamps.yellow;
  assign green       = lamps.green;
  assign walk        = lamps.walk;
  assign halt        = lamps.halt;
  assign req_pending = latch;

endmodule

// File: tb/tb_ped_xing_ctrl_param.sv
// Directed bench for ped_xing_ctrl_param at default parameters.
// Cycle k means the interval just before the k-th rising edge after reset release.
module tb_ped_xing_ctrl_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] x = 2'b00;
  logic       night = 1'b0;
  logic       red, yellow, green, walk, halt, req_pending;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  ped_xing_ctrl_param dut (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .night       (night),
    .red         (red),
    .yellow      (yellow),
    .green       (green),
    .walk        (walk),
    .halt        (halt),
    .req_pending (req_pending)
  );

  always #5 clk = ~clk;

  // {red, yellow, green, walk, halt}
  localparam logic [4:0] L_G  = 5'b00101;
  localparam logic [4:0] L_Y  = 5'b01001;
  localparam logic [4:0] L_W  = 5'b10010;
  localparam logic [4:0] L_C1 = 5'b10001;
  localparam logic [4:0] L_C0 = 5'b10000;
  localparam logic [4:0] L_AR = 5'b10001;
  localparam logic [4:0] L_N1 = 5'b01001;
  localparam logic [4:0] L_N0 = 5'b00001;

  // Expected lamps t cycles after the first yellow cycle of a served request.
  function automatic logic [4:0] seq_lamp(input int t);
    if (t < 0)       return L_G;
    else if (t < 2)  return L_Y;
    else if (t < 6)  return L_W;
    else if (t < 10) return ((t - 6) % 2 == 0) ? L_C1 : L_C0;
    else if (t == 10) return L_AR;
    else             return L_G;
  endfunction

  task automatic check(input string tag, input logic [4:0] lmp, input logic req);
    logic [5:0] obs, expv;
    obs  = {red, yellow, green, walk, halt, req_pending};
    expv = {lmp, req};
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    x     = 2'b00;
    night = 1'b0;
    @(posedge clk);
    #1;
    check("reset_state", L_G, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    // 1: idle
    do_reset();
    for (int k = 0; k < 50; k++) begin
      check("idle", L_G, 1'b0);
      tick();
    end

    // 2: single press at cycle 2
    do_reset();
    for (int k = 0; k < 26; k++) begin
      check("single_press", seq_lamp(k - 8), (k >= 3 && k < 10));
      x = (k == 2) ? 2'b01 : 2'b00;
      tick();
    end

    // 3a: press during WALK dropped
    do_reset();
    for (int k = 0; k < 40; k++) begin
      check("walk_press_dropped", seq_lamp(k - 8), (k >= 3 && k < 10));
      x = (k == 2 || k == 11) ? 2'b01 : 2'b00;
      tick();
    end

    // 3b: press during CLEAR served after full green
    do_reset();
    for (int k = 0; k < 32; k++) begin
      logic [4:0] e;
      e = (k < 19) ? seq_lamp(k - 8) : seq_lamp(k - 27);
      check("clear_press_served", e, (k >= 3 && k < 10) || (k >= 16 && k < 29));
      x = (k == 2 || k == 15) ? 2'b01 : 2'b00;
      tick();
    end

    // 4: night mode with simultaneous press
    do_reset();
    for (int k = 0; k < 30; k++) begin
      logic [4:0] e;
      if (k < 4)       e = L_G;
      else if (k < 21) e = ((k - 4) % 2 == 0) ? L_N1 : L_N0;
      else if (k == 21) e = L_AR;
      else             e = L_G;
      check("night", e, 1'b0);
      x     = (k == 3) ? 2'b10 : 2'b00;
      night = (k >= 3 && k < 20);
      tick();
    end
    night = 1'b0;

    // 5: asynchronous reset mid-WALK
    do_reset();
    for (int k = 0; k < 11; k++) begin
      x = (k == 2) ? 2'b01 : 2'b00;
      tick();
    end
    check("pre_reset_walk", L_W, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", L_G, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc   = 0;
    for (int k = 0; k < 12; k++) begin
      check("after_reset_green_min", seq_lamp(k - 8), (k >= 1 && k < 10));
      x = (k == 0) ? 2'b01 : 2'b00;
      tick();
    end

    // 6: press held continuously
    do_reset();
    x = 2'b11;
    for (int k = 0; k < 70; k++) begin
      logic [4:0] e;
      logic       r;
      int         t;
      t = (k >= 8) ? (k - 8) % 19 : -1;
      e = seq_lamp(t);
      r = (k >= 1) && !(t >= 2 && t <= 6);
      check("held_press", e, r);
      tick();
    end
    x = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
